// File: rtl/div_unit.sv
// div_unit: sequential radix-2 restoring divider for the EX-stage HI/LO path.
// Produces quotient (o_lo) and remainder (o_hi) one quotient bit per cycle,
// with a start/busy/done handshake. A pipeline flush aborts it via i_cancel.
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   : i_sign selects signed DIV (1) or unsigned DIVU (0)
//   undefined : every operation is unsigned, i_sign is ignored
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      request, sampled only in IDLE or DONE
//   i_sign       1 = signed DIV, 0 = DIVU (sampled with i_start)
//   i_cancel     abort, sampled every cycle
//   i_dividend   numerator
//   i_divisor    denominator
//   o_busy       high while CALC or FIX
//   o_done       one-cycle pulse, o_hi/o_lo valid from this cycle
//   o_div_zero   last completed operation had a zero divisor
//   o_hi         remainder
//   o_lo         quotient
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sign,
  input  logic             i_cancel,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  // Partial remainder is always < divisor magnitude between iterations, so
  // only the shifted value (w_rem_sh) needs the extra WIDTH+1-th bit.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs_mag;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_div_zero;

  logic             w_idle_or_done, w_accept, w_dvs_zero, w_ge;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic [WIDTH-1:0] w_lo_fix, w_hi_fix;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  // cancel wins over a simultaneous start
  assign w_accept       = w_idle_or_done && i_start && !i_cancel;
  assign w_dvs_zero     = (i_divisor == '0);

  // One restoring step: shift {R,Q} left, subtract if the trial is >= 0.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs_mag});

`ifdef DIV_SIGNED_EN
  logic r_q_neg, r_r_neg;

  // Magnitude only when signed and negative; unsigned MSB-set values pass through.
  assign w_dvd_mag = (i_sign && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
  assign w_dvs_mag = (i_sign && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (w_accept && !w_dvs_zero) begin
      r_q_neg <= i_sign & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
      r_r_neg <= i_sign & i_dividend[WIDTH-1];
    end
  end

  // Signed overflow (MIN / -1) wraps to MIN here with no special case.
  assign w_lo_fix = r_q_neg ? -r_quo : r_quo;
  assign w_hi_fix = r_r_neg ? -r_rem : r_rem;
`else
  logic w_unused_sign;
  assign w_unused_sign = i_sign;
  assign w_dvd_mag     = i_dividend;
  assign w_dvs_mag     = i_divisor;
  assign w_lo_fix      = r_quo;
  assign w_hi_fix      = r_rem;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
        else          w_state_nxt = S_IDLE;
      end
      S_CALC: begin
        if (i_cancel)                w_state_nxt = S_IDLE;
        else if (r_cnt == LAST_ITER) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_state_nxt = i_cancel ? S_IDLE : S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs_mag  <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_dvs_zero) begin
              r_lo       <= '1;
              r_hi       <= i_dividend;
              r_div_zero <= 1'b1;
            end else begin
              r_quo     <= w_dvd_mag;
              r_dvs_mag <= w_dvs_mag;
              r_rem     <= '0;
              r_cnt     <= '0;
            end
          end
        end
        S_CALC: begin
          if (!i_cancel) begin
            // Result of a successful subtract is < divisor, so it fits WIDTH bits.
            r_rem <= w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs_mag) : w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!i_cancel) begin
            r_lo       <= w_lo_fix;
            r_hi       <= w_hi_fix;
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state == S_CALC) || (r_state == S_FIX);
  assign o_done     = (r_state == S_DONE);
  assign o_div_zero = r_div_zero;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sign = 1'b0, cancel = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sign(sign), .i_cancel(cancel),
    .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy), .o_done(done), .o_div_zero(div_zero), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          at;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  logic [31:0] last_lo = '0, last_hi = '0;
  logic        last_dz = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; C-style truncating division.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint na, nb, qq, rr;
    e.at = 0;
    if (b == 0) begin
      e.lo = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1;
    end else begin
      if (s && SIGNED_EN) begin
        na = $signed(a); nb = $signed(b);
      end else begin
        na = {32'h0, a}; nb = {32'h0, b};
      end
      qq = na / nb;
      rr = na % nb;
      e.lo = qq[31:0]; e.hi = rr[31:0]; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit expect_it);
    exp_t e;
    start = 1'b1; sign = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (expect_it) begin
      e = model(a, b, s);
      e.at = (b == 0) ? cyc : cyc + 33;
      q.push_back(e);
      last_lo = e.lo; last_hi = e.hi; last_dz = e.dz;
    end
  endtask

  task automatic wait_done(input int bound, input int exp_busy, input string nm);
    int n = 0, nb = 0;
    bit seen = 0;
    while (!seen && n < bound) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) seen = 1;
      n++;
    end
    chk({nm, "_done_seen"}, seen, 1);
    if (exp_busy >= 0) chk({nm, "_busy_cycles"}, nb, exp_busy);
  endtask

  task automatic expect_quiet(input int cycles, input string nm);
    int nd = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk({nm, "_quiet"}, nd, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("result_lo", lo, e.lo);
        chk("result_hi", hi, e.hi);
        chk("result_dz", div_zero, e.dz);
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    int          r;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst_n = 1'b1;

    @(negedge clk); issue(100, 7, 0, 1);                       wait_done(50, 33, "divu_100_7");
    @(negedge clk); issue(32'hFFFFFFF9, 2, 1, 1);              wait_done(50, 33, "m7_2");
    chk("cfg_lo", lo, SIGNED_EN ? 32'hFFFFFFFD : 32'h7FFFFFFC);
    chk("cfg_hi", hi, SIGNED_EN ? 32'hFFFFFFFF : 32'h00000001);
    @(negedge clk); issue(7, 32'hFFFFFFFE, 1, 1);              wait_done(50, 33, "7_m2");
    @(negedge clk); issue(32'h80000000, 32'hFFFFFFFF, 1, 1);   wait_done(50, 33, "ovf");
    @(negedge clk); issue(32'h80000000, 32'h80000000, 0, 1);   wait_done(50, 33, "msb_u");

    @(negedge clk); issue(32'h12345678, 0, 1, 1);              wait_done(3, 0, "divzero");
    chk("dz_flag", div_zero, 1);
    @(negedge clk); issue(9, 3, 0, 1);                         wait_done(50, 33, "after_zero");
    chk("dz_cleared", div_zero, 0);

    // start issued mid-CALC is ignored
    @(negedge clk); issue(1000, 9, 0, 1);
    repeat (5) @(negedge clk);
    start = 1'b1; dividend = 77; divisor = 1;
    @(negedge clk); start = 1'b0;
    wait_done(50, -1, "midcalc");

    // cancel at start+10
    @(negedge clk); issue(100, 7, 0, 0);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    expect_quiet(40, "cancel");
    chk("cancel_hold_lo", lo, last_lo);
    chk("cancel_hold_hi", hi, last_hi);
    chk("cancel_hold_dz", div_zero, last_dz);

    // cancel with start in IDLE drops the start
    start = 1'b1; cancel = 1'b1; dividend = 10; divisor = 2;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    expect_quiet(3, "cancel_idle");

    // reset mid-CALC at start+20
    issue(100, 7, 0, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dz", div_zero, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    expect_quiet(40, "after_rst");
    issue(50, 5, 0, 1);                                        wait_done(50, 33, "rst_50_5");
    chk("rst_50_5_lo", lo, 10);
    chk("rst_50_5_hi", hi, 0);

    // back-to-back: start held in DONE
    @(negedge clk); issue(1234567, 89, 0, 1);                  wait_done(50, 33, "b2b_1");
    issue(32'hDEADBEEF, 1234, 0, 1);                           wait_done(50, 33, "b2b_2");
    // cancel + start in DONE: done already pulsed, start dropped
    start = 1'b1; cancel = 1'b1; dividend = 1; divisor = 1;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    expect_quiet(3, "cancel_done");

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      r = $urandom_range(0, 7);
      case (r)
        0:       b = 0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'h80000000;
        default: b = $urandom;
      endcase
      @(negedge clk);
      issue(a, b, 1'($urandom_range(0, 1)), 1);
      wait_done(50, (b == 0) ? 0 : 33, "rand");
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
